// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped data cache.
//   state_t     : controller FSM states
//   *_W / *_LSB : address field widths and positions for the default
//                 4-line, 10-bit byte address, 128-bit block geometry
package cache_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int BLK_W    = 128;
  localparam int WORDS    = BLK_W / DATA_W;
  localparam int WORD_W   = 2;
  localparam int IDX_W    = 2;
  localparam int TAG_W    = 4;
  localparam int OFF_W    = 4;              // byte offset within a block
  localparam int WORD_LSB = 2;
  localparam int IDX_LSB  = OFF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  // Word-in-block field of a byte address.
  function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return a[WORD_LSB +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage for the cache: valid/dirty/tag/data per line.
//   idx                 : line selected for both the read and the write port
//   fill_en/tag/data    : full-block refill (valid=1, dirty=0, new tag)
//   word_en/sel/data    : single-word write into the line (sets dirty)
//   clr_dirty           : clear the dirty bit after a write-back
//   rd_*                : combinational view of the selected line
// Valid/dirty reset asynchronously; tag and data are not reset.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IW        = 2,
  parameter int TW        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     idx,
  input  logic              fill_en,
  input  logic [TW-1:0]     fill_tag,
  input  logic [BLK_W-1:0]  fill_data,
  input  logic              word_en,
  input  logic [WORD_W-1:0] word_sel,
  input  logic [DATA_W-1:0] word_data,
  input  logic              clr_dirty,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TW-1:0]     rd_tag,
  output logic [BLK_W-1:0]  rd_data
);

  logic [NUM_LINES-1:0]            valid_q, valid_d;
  logic [NUM_LINES-1:0]            dirty_q, dirty_d;
  logic [NUM_LINES-1:0][TW-1:0]    tag_q,   tag_d;
  logic [NUM_LINES-1:0][BLK_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = fill_tag;
      data_d[idx]  = fill_data;
    end
    if (word_en) begin
      data_d[idx][word_sel*DATA_W +: DATA_W] = word_data;
      dirty_d[idx] = 1'b1;
    end
    if (clr_dirty) dirty_d[idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
//   cpu_req/we/addr/wdata : request, accepted when cpu_ready=1
//   cpu_ready             : controller idle
//   cpu_done / cpu_rdata  : one-cycle completion pulse, read word (held)
//   mem_write/addr/wdata  : block write-back strobe, block address, victim
//   mem_rdata             : refill block from main memory
// All memory-side outputs are flops decoded from the next state, so the
// combinational-write memory never sees a glitching strobe.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata
);

  localparam int IW    = $clog2(NUM_LINES);
  localparam int TW    = ADDR_W - IDX_LSB - IW;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_we_q, req_we_d;
  logic [TW-1:0]       req_tag_q, req_tag_d;
  logic [IW-1:0]       req_idx_q, req_idx_d;
  logic [WORD_W-1:0]   req_word_q, req_word_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic                fill_en, word_en, clr_dirty;
  logic                rd_valid, rd_dirty;
  logic [TW-1:0]       rd_tag;
  logic [BLK_W-1:0]    rd_data;
  logic                hit, cnt_last;
  logic                addr_lsb_unused;

  // Byte-within-word bits carry no information for word accesses.
  assign addr_lsb_unused = ^cpu_addr[WORD_LSB-1:0];

  cache_line_array #(.NUM_LINES(NUM_LINES), .IW(IW), .TW(TW)) u_lines (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (req_idx_q),
    .fill_en  (fill_en),
    .fill_tag (req_tag_q),
    .fill_data(mem_rdata),
    .word_en  (word_en),
    .word_sel (req_word_q),
    .word_data(req_wdata_q),
    .clr_dirty(clr_dirty),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit      = rd_valid && (rd_tag == req_tag_q);
  assign cnt_last = (cnt_q == CNT_W'(MEM_LAT - 1));

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_word_d  = req_word_q;
    req_wdata_d = req_wdata_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    fill_en     = 1'b0;
    word_en     = 1'b0;
    clr_dirty   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_tag_d   = cpu_addr[ADDR_W-1 -: TW];
          req_idx_d   = cpu_addr[IDX_LSB +: IW];
          req_word_d  = word_of(cpu_addr);
          req_wdata_d = cpu_wdata;
          state_d     = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          if (req_we_q) word_en = 1'b1;
          else          rdata_d = rd_data[req_word_q*DATA_W +: DATA_W];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = rd_dirty ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (cnt_last) begin
          clr_dirty = 1'b1;
          state_d   = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        // Refill on the last cycle; the retried compare then always hits.
        if (cnt_last) begin
          fill_en = 1'b1;
          state_d = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Latency counter restarts on every state entry.
    if ((state_d != state_q) || !(state_q inside {S_WRITEBACK, S_ALLOCATE}))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    // Memory-side outputs registered from the next state. The victim line
    // is untouched during WRITEBACK, so rd_tag/rd_data stay stable there.
    mem_write_d = (state_d == S_WRITEBACK);
    mem_wdata_d = (state_d == S_WRITEBACK) ? rd_data : '0;
    unique case (state_d)
      S_WRITEBACK: mem_addr_d = {rd_tag,    req_idx_q, {OFF_W{1'b0}}};
      S_ALLOCATE:  mem_addr_d = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
      default:     mem_addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_we_q    <= 1'b0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_we_q    <= req_we_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_word_q  <= req_word_d;
      req_wdata_q <= req_wdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_ready = (state_q == S_IDLE);
  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios followed by random
// word reads/writes, checked against a word-level cache/memory model.
module tb_cache_ctrl;

  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready, cpu_done;
  logic [31:0]  cpu_rdata;
  logic         mem_write;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  cache_ctrl #(.NUM_LINES(4), .MEM_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Main memory: 64 blocks, combinational read.
  logic [127:0] mem [64];
  assign mem_rdata = mem[mem_addr[9:4]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:4]] <= mem_wdata;

  // Memory-side monitor.
  int           wb_cyc, mem_act, bad_idle;
  logic [9:0]   wb_addr_seen;
  logic [127:0] wb_data_seen;
  always @(negedge clk) begin
    if (mem_write) begin
      wb_cyc++;
      wb_addr_seen = mem_addr;
      wb_data_seen = mem_wdata;
    end
    if (mem_write || mem_addr != 0) mem_act++;
    if (!mem_write && mem_wdata != 0) bad_idle++;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: cache contents per line plus the word image of memory.
  bit          m_valid [4];
  bit          m_dirty [4];
  int          m_tag   [4];
  logic [31:0] m_data  [4][4];
  logic [31:0] m_mem   [256];
  logic [31:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    m_rdata = 0;
  endtask

  task automatic model_access(input bit we, input logic [9:0] a, input logic [31:0] wd,
                              output int lat, output bit hit, output bit wb,
                              output logic [9:0] wb_a, output logic [127:0] wb_d);
    int idx = int'(a[5:4]);
    int tag = int'(a[9:6]);
    int w   = int'(a[3:2]);
    wb = 0; wb_a = 0; wb_d = 0;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    lat = 1;
    if (!hit) begin
      lat = 2 + L;
      if (m_valid[idx] && m_dirty[idx]) begin
        wb   = 1;
        lat += L;
        wb_a = 10'(m_tag[idx] * 64 + idx * 16);
        for (int k = 0; k < 4; k++) begin
          wb_d[32*k +: 32] = m_data[idx][k];
          m_mem[m_tag[idx] * 16 + idx * 4 + k] = m_data[idx][k];
        end
      end
      for (int k = 0; k < 4; k++) m_data[idx][k] = m_mem[tag * 16 + idx * 4 + k];
      m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tag;
    end
    if (we) begin
      m_data[idx][w] = wd;
      m_dirty[idx]   = 1;
    end else begin
      m_rdata = m_data[idx][w];
    end
  endtask

  // One request: drive, wait for done (bounded), check latency, data and
  // memory traffic. Spurious cpu_req pulses are thrown in while busy.
  task automatic do_req(input bit we, input logic [9:0] a, input logic [31:0] wd);
    int lat, exp_lat; bit hit, wb, got;
    logic [9:0] wb_a; logic [127:0] wb_d;
    model_access(we, a, wd, exp_lat, hit, wb, wb_a, wb_d);
    wb_cyc = 0; mem_act = 0;
    @(negedge clk);
    chk("ready_idle", cpu_ready, 1);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 0;
    lat = 0; got = 0;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_done) got = 1;
      else if ($urandom_range(0, 3) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 10'($urandom); cpu_wdata = $urandom;
      end else cpu_req = 0;
    end
    cpu_req = 0;
    if (!got) chk("timeout", 0, 1);
    chk("latency", lat, exp_lat);
    chk("rdata", cpu_rdata, m_rdata);
    chk("wb_cycles", wb_cyc, wb ? L : 0);
    if (wb) begin
      chk("wb_addr", wb_addr_seen, wb_a);
      chk("wb_data", wb_data_seen, wb_d);
    end
    if (hit) chk("hit_no_mem", mem_act, 0);
    if ($urandom_range(0, 1) == 0) begin
      @(posedge clk); #1;
      chk("done_pulse", cpu_done, 0);
    end
  endtask

  initial begin
    int n;
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) mem[b][32*k +: 32] = 32'(4 * b + k);
    for (int i = 0; i < 256; i++) m_mem[i] = 32'(i);
    model_reset();

    // Reset with a pending request.
    rst_n = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 10'h014; cpu_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    @(negedge clk); cpu_req = 0; rst_n = 1;

    // Cold read, then hit.
    do_req(0, 10'h014, 0);
    chk("cold_rd_val", cpu_rdata, 32'd5);
    do_req(0, 10'h014, 0);
    // Write hit then read back.
    do_req(1, 10'h018, 32'h0000ABCD);
    do_req(0, 10'h018, 0);
    chk("wr_rd_val", cpu_rdata, 32'h0000ABCD);
    // Dirty conflict.
    do_req(0, 10'h058, 0);
    chk("conf_rd_val", cpu_rdata, 32'd22);
    chk("conf_wb_addr", wb_addr_seen, 10'h010);
    chk("conf_wb_data", wb_data_seen, {32'd7, 32'h0000ABCD, 32'd5, 32'd4});

    // Reset in the middle of a write-back.
    do_req(1, 10'h058, 32'h12345678);
    begin
      int lat; bit hit, wb; logic [9:0] wa; logic [127:0] wd;
      model_access(0, 10'h018, 0, lat, hit, wb, wa, wd);
      chk("mid_rst_is_wb", wb, 1);
    end
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h018;
    @(posedge clk); #1;
    cpu_req = 0;
    n = 0;
    while (!mem_write && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("mid_wb_active", mem_write, 1);
    rst_n = 0;
    #1;
    chk("async_mem_write", mem_write, 0);
    chk("async_mem_addr", mem_addr, 0);
    chk("async_mem_wdata", mem_wdata, 0);
    chk("async_ready", cpu_ready, 1);
    chk("async_done", cpu_done, 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    do_req(0, 10'h018, 0);
    chk("post_rst_val", cpu_rdata, 32'h0000ABCD);

    // Random traffic over four tags so lines conflict and hit often.
    for (int i = 0; i < 300; i++)
      do_req(1'($urandom_range(0, 1)), 10'($urandom_range(0, 255)), $urandom);

    chk("mem_wdata_idle_zero", bad_idle, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
